// File: rtl/key_search_ctrl.sv
// key_search_ctrl: top-level sequencer for the RC4 key-search engine.
//
// Starts NUM_CORES datapath cores on their own key sub-ranges. It watches
// their done/found flags, latches the first key found (lowest core index
// wins on a tie) and aborts the rest. The result and the number of RUN
// cycles go to the display/LED logic.
//
// Optional build macro: KEY_SEARCH_TIMEOUT_EN
//   defined   : RUN also ends when elapsed_cycles reaches MAX_CYCLES, and
//               timeout is set (a find on the same edge wins).
//   undefined : no limit comparator; timeout is tied to 0.
//
// Handshake: start is a one-cycle request. It is sampled only in IDLE or
// DONE and ignored elsewhere. core_done is a level from each core.
// core_found is meaningful only while the matching core_done is high.
// Nothing is back-pressured.
//
// Debug: state_dbg exposes the FSM state (IDLE=0, START=1, RUN=2, ABORT=3,
// DONE=4).

module key_search_ctrl #(
    parameter int          NUM_CORES    = 4,
    parameter int unsigned KEY_SPACE    = 32'h0040_0000,
    parameter int          ABORT_CYCLES = 2,
    parameter logic [31:0] MAX_CYCLES   = 32'hFFFF_FFFF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [NUM_CORES-1:0]      core_done,
    input  logic [NUM_CORES-1:0]      core_found,
    input  logic [24*NUM_CORES-1:0]   core_key,
    output logic [NUM_CORES-1:0]      core_start,
    output logic                      core_abort,
    output logic [24*NUM_CORES-1:0]   core_base,
    output logic [23:0]               found_key,
    output logic                      key_found,
    output logic                      search_done,
    output logic                      busy,
    output logic                      timeout,
    output logic [31:0]               elapsed_cycles,
    output logic [2:0]                state_dbg
);

    // Each core searches KEY_SPACE/NUM_CORES consecutive keys.
    localparam int unsigned SUB_RANGE = KEY_SPACE / NUM_CORES;

    // The abort counter runs 0 .. ABORT_CYCLES-1.
    localparam int AW = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;
    localparam logic [AW-1:0] ABORT_LAST = AW'(ABORT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_ABORT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state;
    logic [NUM_CORES-1:0]   done_mask;
    logic [AW-1:0]          abort_cnt;

    logic [NUM_CORES-1:0]   hit;
    logic                   any_hit;
    logic [23:0]            win_key;
    logic                   all_done;
    logic [31:0]            elapsed_next;

`ifdef KEY_SEARCH_TIMEOUT_EN
    logic                   limit_hit;
    logic                   timeout_q;
`endif

    // Base keys are elaboration-time constants and need no register.
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_base
        localparam logic [23:0] BASE = 24'(gi * SUB_RANGE);
        assign core_base[24*gi +: 24] = BASE;
    end

    assign state_dbg = state;

    // Winner selection: the scan runs from high to low index, so the lowest
    // index that reports done and found is the one left in win_key.
    always_comb begin
        hit     = core_done & core_found;
        any_hit = |hit;
        win_key = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_key = core_key[24*i +: 24];
            end
        end
    end

    // The search is over once every core has reported done at some point,
    // counting the flags present on this cycle.
    assign all_done = &(done_mask | core_done);

    // Elapsed counter saturates instead of wrapping.
    assign elapsed_next = (elapsed_cycles == 32'hFFFF_FFFF) ?
                          elapsed_cycles : elapsed_cycles + 32'd1;

`ifdef KEY_SEARCH_TIMEOUT_EN
    // The limit applies to the count that this RUN edge will store.
    assign limit_hit = (elapsed_next >= MAX_CYCLES);
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

    // Search sequencer with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            core_start     <= '0;
            core_abort     <= 1'b1;
            found_key      <= '0;
            key_found      <= 1'b0;
            search_done    <= 1'b0;
            busy           <= 1'b0;
            elapsed_cycles <= '0;
            done_mask      <= '0;
            abort_cnt      <= '0;
`ifdef KEY_SEARCH_TIMEOUT_EN
            timeout_q      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // Cores leave abort once the controller is idle. In DONE
                    // this is already 0.
                    core_abort <= 1'b0;
                    if (start) begin
                        // Enter START. The previous result is cleared here, so
                        // it reads zero for the whole START cycle.
                        state          <= S_START;
                        core_abort     <= 1'b1;
                        core_start     <= '0;
                        busy           <= 1'b1;
                        search_done    <= 1'b0;
                        found_key      <= '0;
                        key_found      <= 1'b0;
                        elapsed_cycles <= '0;
                        done_mask      <= '0;
`ifdef KEY_SEARCH_TIMEOUT_EN
                        timeout_q      <= 1'b0;
`endif
                    end
                end

                S_START: begin
                    state      <= S_RUN;
                    core_abort <= 1'b0;
                    core_start <= '1;
                end

                S_RUN: begin
                    elapsed_cycles <= elapsed_next;
                    done_mask      <= done_mask | core_done;
                    if (any_hit) begin
                        found_key  <= win_key;
                        key_found  <= 1'b1;
                        state      <= S_ABORT;
                        core_start <= '0;
                        core_abort <= 1'b1;
                        abort_cnt  <= '0;
                    end else if (all_done) begin
                        state      <= S_ABORT;
                        core_start <= '0;
                        core_abort <= 1'b1;
                        abort_cnt  <= '0;
                    end
`ifdef KEY_SEARCH_TIMEOUT_EN
                    else if (limit_hit) begin
                        timeout_q  <= 1'b1;
                        state      <= S_ABORT;
                        core_start <= '0;
                        core_abort <= 1'b1;
                        abort_cnt  <= '0;
                    end
`endif
                end

                S_ABORT: begin
                    // Hold the cores in reset for ABORT_CYCLES cycles.
                    // Their flags are ignored here.
                    if (abort_cnt == ABORT_LAST) begin
                        state       <= S_DONE;
                        core_abort  <= 1'b0;
                        busy        <= 1'b0;
                        search_done <= 1'b1;
                    end else begin
                        abort_cnt <= abort_cnt + AW'(1);
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    core_start <= '0;
                    core_abort <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_search_ctrl.sv
// tb_key_search_ctrl: self-checking bench for key_search_ctrl.
//
// Each search is described by a per-core table: the RUN cycle at which the
// core raises done, whether it also raises found, and its key. The model
// works out from that table when the search ends, who wins and with what
// key. It then lists the expected outputs for every cycle after the start
// request. A separate compare process checks the DUT against that list.

module tb_key_search_ctrl;

    localparam int NC = 4;
    localparam int AC = 2;
`ifdef KEY_SEARCH_TIMEOUT_EN
    localparam int          MAXC  = 100;
    localparam logic [31:0] MAXP  = 32'd100;
`else
    localparam int          MAXC  = 0;
    localparam logic [31:0] MAXP  = 32'hFFFF_FFFF;
`endif
    localparam int EW = NC + 5 + 24 + 32;

    logic                 clk;
    logic                 reset_n;
    logic                 start;
    logic [NC-1:0]        core_done;
    logic [NC-1:0]        core_found;
    logic [24*NC-1:0]     core_key;
    logic [NC-1:0]        core_start;
    logic                 core_abort;
    logic [24*NC-1:0]     core_base;
    logic [23:0]          found_key;
    logic                 key_found;
    logic                 search_done;
    logic                 busy;
    logic                 timeout;
    logic [31:0]          elapsed_cycles;
    logic [2:0]           state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [EW-1:0] exp_q[$];

    // Scenario table: RUN cycle of done, found flag and key for each core.
    int          d[NC];
    bit          f[NC];
    logic [23:0] k[NC];

    key_search_ctrl #(
        .NUM_CORES    (NC),
        .KEY_SPACE    (32'h0040_0000),
        .ABORT_CYCLES (AC),
        .MAX_CYCLES   (MAXP)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .core_done      (core_done),
        .core_found     (core_found),
        .core_key       (core_key),
        .core_start     (core_start),
        .core_abort     (core_abort),
        .core_base      (core_base),
        .found_key      (found_key),
        .key_found      (key_found),
        .search_done    (search_done),
        .busy           (busy),
        .timeout        (timeout),
        .elapsed_cycles (elapsed_cycles),
        .state_dbg      (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle with a queued expectation is checked.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("core_start",     64'(core_start),     64'(e[EW-1 -: NC]));
            chk("core_abort",     64'(core_abort),     64'(e[EW-NC-1]));
            chk("busy",           64'(busy),           64'(e[EW-NC-2]));
            chk("search_done",    64'(search_done),    64'(e[EW-NC-3]));
            chk("key_found",      64'(key_found),      64'(e[EW-NC-4]));
            chk("timeout",        64'(timeout),        64'(e[EW-NC-5]));
            chk("found_key",      64'(found_key),      64'(e[55:32]));
            chk("elapsed_cycles", 64'(elapsed_cycles), 64'(e[31:0]));
        end
    end

    // ---------------- driver ----------------
    // Runs one search from IDLE or DONE. Segment n is the cycle between the
    // (n-1)-th and n-th clock edge after the edge that samples start.
    // rst_at != 0 pulls reset_n low during segment rst_at and ends the search.
    task automatic run_search(input bit rand_start, input int rst_at);
        int          endc;
        int          t_all;
        bit          fnd;
        bit          to;
        logic [23:0] wkey;
        logic [NC-1:0] cs;
        logic ab, bz, sd;
        logic [31:0] el;

        // Model: earliest finder wins. On equal cycles the lower index wins,
        // because only a strictly earlier cycle replaces the current winner.
        endc = 1 << 30;
        fnd  = 1'b0;
        wkey = '0;
        t_all = 0;
        for (int i = 0; i < NC; i++) begin
            if (f[i] && d[i] < endc) begin
                endc = d[i];
                wkey = k[i];
                fnd  = 1'b1;
            end
            if (d[i] > t_all) t_all = d[i];
        end
        // Cores done with no find end the search. A find on the same cycle
        // takes priority.
        if (t_all < endc) begin
            endc = t_all;
            fnd  = 1'b0;
            wkey = '0;
        end
        to = 1'b0;
        if (MAXC > 0 && MAXC < endc) begin
            endc = MAXC;
            fnd  = 1'b0;
            wkey = '0;
            to   = 1'b1;
        end

        for (int i = 0; i < NC; i++) core_key[24*i +: 24] = k[i];

        // Segment 0: request.
        @(posedge clk); #1;
        start      = 1'b1;
        core_done  = '0;
        core_found = '0;

        for (int n = 1; n <= endc + AC + 3; n++) begin
            @(posedge clk); #1;
            if (rst_at != 0 && n == rst_at) begin
                reset_n = 1'b0;
                start = 1'b0;
                core_done = '0;
                core_found = '0;
                #1;
                chk("rst_core_abort",  64'(core_abort),     64'd1);
                chk("rst_busy",        64'(busy),           64'd0);
                chk("rst_core_start",  64'(core_start),     64'd0);
                chk("rst_key_found",   64'(key_found),      64'd0);
                chk("rst_found_key",   64'(found_key),      64'd0);
                chk("rst_elapsed",     64'(elapsed_cycles), 64'd0);
                chk("rst_search_done", 64'(search_done),    64'd0);
                #2;
                reset_n = 1'b1;
                return;
            end
            if (n == 1) begin
                cs = '0; ab = 1'b1; bz = 1'b1; sd = 1'b0; el = 32'd0;
                exp_q.push_back({cs, ab, bz, sd, 1'b0, 1'b0, 24'h0, el});
            end else if (n <= endc + 1) begin
                cs = '1; ab = 1'b0; bz = 1'b1; sd = 1'b0; el = 32'(n - 2);
                exp_q.push_back({cs, ab, bz, sd, 1'b0, 1'b0, 24'h0, el});
            end else if (n <= endc + 1 + AC) begin
                cs = '0; ab = 1'b1; bz = 1'b1; sd = 1'b0; el = 32'(endc);
                exp_q.push_back({cs, ab, bz, sd, fnd, to, wkey, el});
            end else begin
                cs = '0; ab = 1'b0; bz = 1'b0; sd = 1'b1; el = 32'(endc);
                exp_q.push_back({cs, ab, bz, sd, fnd, to, wkey, el});
            end
            // A stray start outside IDLE/DONE must be ignored.
            start = (rand_start && n <= endc + 1 + AC) ? 1'($urandom_range(0, 1)) : 1'b0;
            for (int i = 0; i < NC; i++) begin
                core_done[i]  = (n - 1 >= d[i]);
                core_found[i] = (n - 1 >= d[i]) && f[i];
            end
        end
    endtask

    task automatic set_core(input int i, input int dd, input bit ff, input logic [23:0] kk);
        d[i] = dd;
        f[i] = ff;
        k[i] = kk;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        core_done  = '0;
        core_found = '0;
        core_key   = '0;
        for (int i = 0; i < NC; i++) set_core(i, 1, 1'b0, 24'h0);

        #12;
        // Reset state.
        chk("reset_core_abort", 64'(core_abort),     64'd1);
        chk("reset_busy",       64'(busy),           64'd0);
        chk("reset_key_found",  64'(key_found),      64'd0);
        chk("reset_elapsed",    64'(elapsed_cycles), 64'd0);
        chk("reset_timeout",    64'(timeout),        64'd0);
        for (int i = 0; i < NC; i++)
            chk("core_base", 64'(core_base[24*i +: 24]), 64'(i * 32'h10_0000));
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_core_abort", 64'(core_abort), 64'd0);
        chk("idle_busy",       64'(busy),       64'd0);

        // Core 2 finds 24'h2000A7 at RUN cycle 50.
        set_core(0, 90, 1'b0, 24'h000011);
        set_core(1, 90, 1'b0, 24'h100022);
        set_core(2, 50, 1'b1, 24'h2000A7);
        set_core(3, 90, 1'b0, 24'h300033);
        run_search(1'b0, 0);
        chk("t1_found_key",   64'(found_key),      64'h2000A7);
        chk("t1_key_found",   64'(key_found),      64'd1);
        chk("t1_elapsed",     64'(elapsed_cycles), 64'd50);
        chk("t1_search_done", 64'(search_done),    64'd1);

        // Cores 1 and 3 find on the same cycle; core 1 wins.
        set_core(0, 70, 1'b0, 24'h000055);
        set_core(1, 30, 1'b1, 24'h100001);
        set_core(2, 70, 1'b0, 24'h200066);
        set_core(3, 30, 1'b1, 24'h300002);
        run_search(1'b0, 0);
        chk("t2_found_key", 64'(found_key), 64'h100001);

        // Restart from DONE with key_found set; core 0 finds 24'h000249.
        set_core(0, 15, 1'b1, 24'h000249);
        set_core(1, 40, 1'b0, 24'h100077);
        set_core(2, 40, 1'b0, 24'h200088);
        set_core(3, 40, 1'b0, 24'h300099);
        run_search(1'b0, 0);
        chk("t3_found_key", 64'(found_key),      64'h000249);
        chk("t3_elapsed",   64'(elapsed_cycles), 64'd15);

        // All cores done without a find at 10/20/30/40.
        set_core(0, 10, 1'b0, 24'h0000AA);
        set_core(1, 20, 1'b0, 24'h1000BB);
        set_core(2, 30, 1'b0, 24'h2000CC);
        set_core(3, 40, 1'b0, 24'h3000DD);
        run_search(1'b0, 0);
        chk("t4_key_found", 64'(key_found),      64'd0);
        chk("t4_found_key", 64'(found_key),      64'd0);
        chk("t4_elapsed",   64'(elapsed_cycles), 64'd40);

        // Reset mid-RUN, then a clean search.
        set_core(0, 200, 1'b1, 24'h0000EE);
        set_core(1, 200, 1'b0, 24'h1000EE);
        set_core(2, 200, 1'b0, 24'h2000EE);
        set_core(3, 200, 1'b0, 24'h3000EE);
        run_search(1'b0, 10);
        set_core(0, 12, 1'b0, 24'h000101);
        set_core(1, 25, 1'b1, 24'h123456);
        set_core(2, 40, 1'b0, 24'h200202);
        set_core(3, 40, 1'b0, 24'h300303);
        run_search(1'b0, 0);
        chk("t5_found_key", 64'(found_key), 64'h123456);

        // No finds and a late finish: the limit applies only in the timeout build.
        for (int i = 0; i < NC; i++) set_core(i, 150, 1'b0, 24'(i));
        run_search(1'b0, 0);
`ifdef KEY_SEARCH_TIMEOUT_EN
        chk("t6_timeout", 64'(timeout),        64'd1);
        chk("t6_elapsed", 64'(elapsed_cycles), 64'd100);
`else
        chk("t6_timeout", 64'(timeout),        64'd0);
        chk("t6_elapsed", 64'(elapsed_cycles), 64'd150);
`endif
        chk("t6_key_found", 64'(key_found), 64'd0);

        // Random searches with stray start pulses and forced ties.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NC; i++)
                set_core(i, $urandom_range(1, 60), ($urandom_range(0, 3) == 0), 24'($urandom));
            if ($urandom_range(0, 2) == 0) d[NC-1] = d[0];
            run_search(1'b1, 0);
        end

        @(posedge clk); #1;
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
